// File: rtl/fifo_sync_level.sv
// Circular FIFO with occupancy count and registered almost-full/almost-empty flags; show-ahead head word, zero-latency write-to-read visibility.
// No backpressure beyond full/empty; define FIFO_ERR_FLAGS_EN for sticky overflow/underflow with clr_err, otherwise dropped requests are ignored.
module fifo_sync_level #(
  parameter int ADR_WIDTH  = 4,
  parameter int DAT_WIDTH  = 8,
  parameter int AFULL_THR  = 12,
  parameter int AEMPTY_THR = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr,
  input  logic                 rd,
  input  logic [DAT_WIDTH-1:0] data_in,
  output logic [DAT_WIDTH-1:0] data_out,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic [ADR_WIDTH:0]   count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  input  logic                 clr_err,
  output logic                 overflow,
  output logic                 underflow
`endif
);

  localparam int DEPTH = 2**ADR_WIDTH;
  localparam logic [ADR_WIDTH:0]   DEPTH_C  = (ADR_WIDTH+1)'(DEPTH);
  localparam logic [ADR_WIDTH:0]   AFULL_C  = (ADR_WIDTH+1)'(AFULL_THR);
  localparam logic [ADR_WIDTH:0]   AEMPTY_C = (ADR_WIDTH+1)'(AEMPTY_THR);
  localparam logic [ADR_WIDTH:0]   CNT_ONE  = {{ADR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADR_WIDTH-1:0] PTR_ONE  = {{(ADR_WIDTH-1){1'b0}}, 1'b1};

  logic [DAT_WIDTH-1:0] mem [DEPTH];
  logic [ADR_WIDTH-1:0] w_ptr;
  logic [ADR_WIDTH-1:0] r_ptr;
  logic [ADR_WIDTH:0]   count_nxt;
  logic                 rd_acc;
  logic                 wr_acc;

  // A read in the same cycle frees the slot, so a full FIFO still takes a write.
  always_comb begin
    rd_acc    = rd & ~empty;
    wr_acc    = wr & (~full | rd);
    count_nxt = count;
    if (wr_acc && !rd_acc) begin
      count_nxt = count + CNT_ONE;
    end else if (!wr_acc && rd_acc) begin
      count_nxt = count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      if (wr_acc) begin
        w_ptr <= w_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        r_ptr <= r_ptr + PTR_ONE;
      end
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == DEPTH_C);
      almost_empty <= (count_nxt <= AEMPTY_C);
      almost_full  <= (count_nxt >= AFULL_C);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_acc) begin
      mem[w_ptr] <= data_in;
    end
  end

  assign data_out = mem[r_ptr];

`ifdef FIFO_ERR_FLAGS_EN
  // A read on empty paired with a write is not an underflow: the write supplies the word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full && !rd) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd && empty && !wr) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_level.sv
// Bench for fifo_sync_level: vector table for fill/overflow/drain, hand sequences for corner cases, random traffic against a queue model.
module tb_fifo_sync_level;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       clr_err = 1'b0;
  logic [7:0] data_out;
  logic       empty, full, almost_empty, almost_full;
  logic [4:0] count;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
`endif

  fifo_sync_level #(
    .ADR_WIDTH(4), .DAT_WIDTH(8), .AFULL_THR(12), .AEMPTY_THR(4)
  ) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .data_in(data_in),
    .data_out(data_out), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count)
`ifdef FIFO_ERR_FLAGS_EN
    , .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: a plain queue of stored words plus the two sticky flags.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    int         e_count;
    logic       e_empty;
    logic       e_full;
    logic       e_ae;
    logic       e_af;
    logic [7:0] e_dout;
  } vec_t;

  vec_t tbl[33];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit ra, wa, ovs, uds;
    if (!reset) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      return;
    end
    ra  = rd && (q.size() > 0);
    wa  = wr && ((q.size() - int'(ra)) < 16);
    ovs = wr && !wa;
    uds = rd && !ra && !wr;
    if (ra) void'(q.pop_front());
    if (wa) q.push_back(data_in);
    m_ovf = ovs ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
    m_udf = uds ? 1'b1 : (clr_err ? 1'b0 : m_udf);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == 16));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(q.size() <= 4));
    chk({tag, ".afull"}, 32'(almost_full), 32'(q.size() >= 12));
    if (q.size() > 0) chk({tag, ".dout"}, 32'(data_out), 32'(q[0]));
`ifdef FIFO_ERR_FLAGS_EN
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(underflow), 32'(m_udf));
`endif
  endtask

  // Drive inputs, take one rising edge, advance the model, sample 1 time unit later.
  task automatic step(input logic w, input logic r, input logic [7:0] d, input string tag);
    wr = w;
    rd = r;
    data_in = d;
    @(posedge clk);
    model_update();
    #1;
    check_model(tag);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[i].w = 1'b1; tbl[i].r = 1'b0; tbl[i].d = 8'(i);
      tbl[i].e_count = i + 1; tbl[i].e_empty = 1'b0; tbl[i].e_full = (i == 15);
      tbl[i].e_ae = (i + 1 <= 4); tbl[i].e_af = (i + 1 >= 12); tbl[i].e_dout = 8'h00;
    end
    tbl[16].w = 1'b1; tbl[16].r = 1'b0; tbl[16].d = 8'hAA;
    tbl[16].e_count = 16; tbl[16].e_empty = 1'b0; tbl[16].e_full = 1'b1;
    tbl[16].e_ae = 1'b0; tbl[16].e_af = 1'b1; tbl[16].e_dout = 8'h00;
    for (int i = 0; i < 16; i++) begin
      tbl[17+i].w = 1'b0; tbl[17+i].r = 1'b1; tbl[17+i].d = 8'hFF;
      tbl[17+i].e_count = 15 - i; tbl[17+i].e_empty = (i == 15); tbl[17+i].e_full = 1'b0;
      tbl[17+i].e_ae = (15 - i <= 4); tbl[17+i].e_af = (15 - i >= 12); tbl[17+i].e_dout = 8'(i + 1);
    end

    // Reset state
    reset = 1'b0;
    step(1'b0, 1'b0, 8'h00, "reset0");
    step(1'b1, 1'b1, 8'h99, "reset1");
    reset = 1'b1;
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.empty", 32'(empty), 32'd1);

    // Fill, overflow attempt, drain
    for (int k = 0; k < 33; k++) begin
      step(tbl[k].w, tbl[k].r, tbl[k].d, $sformatf("vec%0d", k));
      chk($sformatf("vec%0d.count", k), 32'(count), 32'(tbl[k].e_count));
      chk($sformatf("vec%0d.empty", k), 32'(empty), 32'(tbl[k].e_empty));
      chk($sformatf("vec%0d.full", k), 32'(full), 32'(tbl[k].e_full));
      chk($sformatf("vec%0d.aempty", k), 32'(almost_empty), 32'(tbl[k].e_ae));
      chk($sformatf("vec%0d.afull", k), 32'(almost_full), 32'(tbl[k].e_af));
      if (!tbl[k].e_empty) chk($sformatf("vec%0d.dout", k), 32'(data_out), 32'(tbl[k].e_dout));
`ifdef FIFO_ERR_FLAGS_EN
      if (k == 16) chk("overflow_set", 32'(overflow), 32'd1);
`endif
    end
    clr_err = 1'b1;
    step(1'b0, 1'b0, 8'h00, "clr1");
    clr_err = 1'b0;

    // Full with simultaneous write and read
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i), "fill3");
    step(1'b1, 1'b1, 8'h55, "fullwr");
    chk("t3.count", 32'(count), 32'd16);
    chk("t3.full", 32'(full), 32'd1);
    chk("t3.dout", 32'(data_out), 32'h01);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("t3.last", 32'(data_out), 32'h55);
      step(1'b0, 1'b1, 8'h00, "drain3");
    end
    chk("t3.empty", 32'(empty), 32'd1);

    // Empty with simultaneous write and read, then underflow
    step(1'b1, 1'b1, 8'h33, "emptywr");
    chk("t4.count", 32'(count), 32'd1);
    chk("t4.empty", 32'(empty), 32'd0);
    chk("t4.dout", 32'(data_out), 32'h33);
`ifdef FIFO_ERR_FLAGS_EN
    chk("t4.udf0", 32'(underflow), 32'd0);
`endif
    step(1'b0, 1'b1, 8'h00, "pop4");
    step(1'b0, 1'b1, 8'h00, "udf4");
`ifdef FIFO_ERR_FLAGS_EN
    chk("t4.udf1", 32'(underflow), 32'd1);
`endif
    clr_err = 1'b1;
    step(1'b0, 1'b0, 8'h00, "clr4");
    clr_err = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
    chk("t4.udfclr", 32'(underflow), 32'd0);
`endif

    // Random traffic, long enough for several pointer wraps
    for (int i = 0; i < 300; i++) begin
      clr_err = ($urandom_range(0, 15) == 0);
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 55, 8'($urandom), "rand");
    end
    clr_err = 1'b0;

    // Mid-operation reset with 8 words queued
    while (q.size() > 0) step(1'b0, 1'b1, 8'h00, "flush6");
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i), "load6");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, "skew6");
    chk("t6.pre", 32'(count), 32'd8);
    reset = 1'b0;
    step(1'b1, 1'b0, 8'hEE, "rst6");
    reset = 1'b1;
    chk("t6.count", 32'(count), 32'd0);
    chk("t6.empty", 32'(empty), 32'd1);
    chk("t6.full", 32'(full), 32'd0);
    chk("t6.aempty", 32'(almost_empty), 32'd1);
    step(1'b1, 1'b0, 8'h77, "new6");
    chk("t6.dout", 32'(data_out), 32'h77);
    step(1'b0, 1'b1, 8'h00, "read6");
    chk("t6.empty2", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
